// File: rtl/fde_pkg.sv
// -----------------------------------------------------------------------------
// fde_pkg
// Shared definitions for the fetch stage: instruction width, field bit
// positions, the halt opcode and the fetch state enum.
// -----------------------------------------------------------------------------
package fde_pkg;

    localparam int INST_W   = 16;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int SRC1_MSB = 11;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 4;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 0;

    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Synchronous FIFO of {pc, instruction} pairs feeding decode.
//   i_clk, i_rst      clock, synchronous active-high reset (clears entries)
//   i_flush           drop all entries (pointers/count only)
//   i_wr_en/_pc/_inst push a fetched instruction at the tail
//   i_rd_en           pop the head
//   o_head_pc/_inst   head entry (stale when empty)
//   o_count           number of valid entries
// -----------------------------------------------------------------------------
module fetch_buf
    import fde_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_pc,
    input  logic [INST_W-1:0] i_wr_inst,
    input  logic              i_rd_en,
    output logic [AW-1:0]     o_head_pc,
    output logic [INST_W-1:0] o_head_inst,
    output logic [CNT_W-1:0]  o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW+INST_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 do_rd;
    logic                 do_wr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_rd = i_rd_en && (count_q != '0);
    assign do_wr = i_wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= {i_wr_pc, i_wr_inst};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    assign {o_head_pc, o_head_inst} = mem_q[rd_ptr_q];
    assign o_count                  = count_q;

endmodule

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction fetch stage: issues single-cycle-latency reads to instruction
// memory, buffers returned words with their PC, and hands them to decode with
// a valid/ready handshake. Redirects flush the buffer and restart fetch.
//
// Optional feature: define FETCH_HALT_EN to stop fetching once an
// instruction with opcode OPC_HALT is captured (halt word is still delivered).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   o_imem_req/o_imem_addr  memory read request and address (current PC)
//   i_imem_rdata            read data, one cycle after the request
//   i_redirect/_pc          flush and restart at i_redirect_pc
//   o_inst_valid/i_inst_ready, o_instruction, o_pc   decode handshake
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | fetching whenever the buffer has room
// HALT  | halt word captured; no requests, late responses discarded
// -----------------------------------------------------------------------------
module fetch
    import fde_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [INST_W-1:0] i_imem_rdata,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [INST_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc
);

    localparam int                CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic [CNT_W-1:0]  buf_count;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic              pop;
    logic              req;
    logic              wr_en;
    logic [CNT_W:0]    occupancy;

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (ADDR_W)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect),
        .i_wr_en     (wr_en),
        .i_wr_pc     (pend_pc_q),
        .i_wr_inst   (i_imem_rdata),
        .i_rd_en     (pop && !i_redirect),
        .o_head_pc   (head_pc),
        .o_head_inst (head_inst),
        .o_count     (buf_count)
    );

    // Outputs are forced to their reset values while i_rst is high so the
    // very first reset cycle is already clean.
    assign o_inst_valid  = (buf_count != '0) && !i_rst;
    assign o_instruction = i_rst ? '0 : head_inst;
    assign o_pc          = i_rst ? '0 : head_pc;
    assign o_imem_req    = req && !i_rst;
    assign o_imem_addr   = i_rst ? RESET_ADDR : pc_q;

    assign pop = o_inst_valid && i_inst_ready;

    // Slots already spoken for after this cycle: stored entries plus the
    // response in flight, minus the entry decode takes now.
    assign occupancy = (CNT_W+1)'(buf_count) + (CNT_W+1)'(pending_q)
                     - (CNT_W+1)'(pop);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = 1'b0;
        pend_pc_d = pend_pc_q;
        req       = 1'b0;
        wr_en     = 1'b0;

        if (i_redirect) begin
            pc_d    = i_redirect_pc;
            state_d = RUN;
        end else begin
            wr_en = pending_q && (state_q == RUN);
            if ((state_q == RUN) && (occupancy < (CNT_W+1)'(BUF_DEPTH))) begin
                req       = 1'b1;
                pending_d = 1'b1;
                pend_pc_d = pc_q;
                pc_d      = pc_q + ADDR_W'(1);
            end
`ifdef FETCH_HALT_EN
            if (wr_en && (opcode_of(i_imem_rdata) == OPC_HALT)) begin
                state_d = HALT;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_ADDR;
            pending_q <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        valid;
    logic        ready;
    logic [15:0] inst;
    logic [7:0]  pc;

    always #5 clk = ~clk;

    fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (valid),
        .i_inst_ready  (ready),
        .o_instruction (inst),
        .o_pc          (pc)
    );

    // Instruction memory: data valid the cycle after the request.
    logic [15:0] mem [256];
    always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : 16'hDEAD;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [7:0] exp_pc = 8'h00;

    // Reference model: decode must see the straight-line address stream
    // starting at the reset/redirect address, each word equal to mem[pc].
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = 8'h00;
        end else if (redirect) begin
            exp_pc = redirect_pc;
        end else if (valid && ready) begin
            checks++;
            if (pc !== exp_pc || inst !== mem[exp_pc]) begin
                errors++;
                $display("FAIL stream: got pc %h inst %h, want pc %h inst %h",
                         pc, inst, exp_pc, mem[exp_pc]);
            end
            exp_pc = exp_pc + 8'd1;
            acc_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem_linear();
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        fill_mem_linear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== 8'h00 || valid !== 1'b0 ||
                inst !== 16'h0000 || pc !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs: req %b addr %h valid %b inst %h pc %h, want 0 00 0 0000 00",
                         imem_req, imem_addr, valid, inst, pc);
            end
            next_cycle();
        end
    endtask

    task automatic test_startup();
        rst = 1'b1; ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_req: req %b addr %h, want 1 00", imem_req, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid %b, want 0", valid);
        end
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || pc !== 8'(k) || inst !== 16'h1000 + 16'(k)) begin
                errors++;
                $display("FAIL stream_rate: valid %b pc %h inst %h, want 1 %h %h",
                         valid, pc, inst, 8'(k), 16'h1000 + 16'(k));
            end
        end
    endtask

    task automatic test_stall();
        int n;
        rst = 1'b1; ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!valid && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL stall_first_valid: cycles %0d, want 2", n);
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                next_cycle();
                @(negedge clk);
            end
            checks++;
            if (valid !== 1'b1 || pc !== 8'h00 || inst !== 16'h1000 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid %b pc %h inst %h req %b, want 1 00 1000 0",
                         valid, pc, inst, imem_req);
            end
        end
        next_cycle();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || pc !== 8'(i)) begin
                errors++;
                $display("FAIL stall_resume: valid %b pc %h, want 1 %h", valid, pc, 8'(i));
            end
        end
    endtask

    task automatic test_redirect_full();
        rst = 1'b1; ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        // cycle 2: one entry buffered, one response in flight
        redirect = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 8'h00 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle: valid %b pc %h req %b, want 1 00 0", valid, pc, imem_req);
        end
        next_cycle();
        redirect = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL redirect_restart: valid %b req %b addr %h, want 0 1 40", valid, imem_req, imem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: valid %b pc %h, want valid 0", valid, pc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 8'h40 || inst !== mem[8'h40]) begin
            errors++;
            $display("FAIL redirect_target: valid %b pc %h inst %h, want 1 40 %h", valid, pc, inst, mem[8'h40]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] want [4];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
        ready = 1'b1;
        next_cycle();
        redirect = 1'b1; redirect_pc = 8'hFE;
        next_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid && ready) q.push_back(pc);
            next_cycle();
        end
        checks++;
        if (q.size() < 4) begin
            errors++;
            $display("FAIL wrap_count: accepted %0d, want at least 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_pc[%0d]: got %h want %h", i, q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_prefill: valid %b, want 1", valid);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || imem_req !== 1'b0 || inst !== 16'h0000 || pc !== 8'h00 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL midreset_during: valid %b req %b inst %h pc %h addr %h, want 0 0 0000 00 00",
                     valid, imem_req, inst, pc, imem_addr);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || imem_addr !== 8'h00 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after: valid %b addr %h req %b, want 0 00 1", valid, imem_addr, imem_req);
        end
    endtask

    task automatic test_halt();
        logic [7:0] q[$];
        bit seen;
        mem[3] = 16'hF123;
        rst = 1'b1; ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid && ready) q.push_back(pc);
`ifdef FETCH_HALT_EN
            if (c >= 5) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_no_req: cycle %0d req %b, want 0", c, imem_req);
                end
            end
`else
            checks++;
            if (imem_req !== 1'b1) begin
                errors++;
                $display("FAIL nohalt_req: cycle %0d req %b, want 1", c, imem_req);
            end
`endif
            next_cycle();
        end
`ifdef FETCH_HALT_EN
        checks++;
        if (q.size() != 4 || q[0] !== 8'h00 || q[1] !== 8'h01 || q[2] !== 8'h02 || q[3] !== 8'h03) begin
            errors++;
            $display("FAIL halt_delivered: count %0d last %h, want 4 ending 03",
                     q.size(), (q.size() > 0) ? q[q.size()-1] : 8'hxx);
        end
`else
        checks++;
        if (q.size() < 5 || q[3] !== 8'h03 || q[4] !== 8'h04) begin
            errors++;
            $display("FAIL nohalt_follow: count %0d, want pc 03 then 04", q.size());
        end
`endif
        redirect = 1'b1; redirect_pc = 8'h10;
        next_cycle();
        redirect = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!seen || pc !== 8'h10 || inst !== mem[8'h10]) begin
            errors++;
            $display("FAIL halt_resume: valid %b pc %h inst %h, want 1 10 %h", seen, pc, inst, mem[8'h10]);
        end
        next_cycle();
        rst = 1'b1;
        mem[3] = 16'h1003;
        next_cycle();
    endtask

    task automatic test_random();
        int start_acc;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            mem[i] = {op, 12'($urandom)};
        end
        next_cycle();
        rst = 1'b0;
        start_acc = acc_cnt;
        for (int c = 0; c < 600; c++) begin
            ready       = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            rst         = ($urandom_range(0, 63) == 0);
            next_cycle();
        end
        rst = 1'b0; redirect = 1'b0; ready = 1'b1;
        next_cycle();
        checks++;
        if (acc_cnt - start_acc < 100) begin
            errors++;
            $display("FAIL random_progress: accepted %0d, want at least 100", acc_cnt - start_acc);
        end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        test_reset();
        test_startup();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
